ram_read_sequencer: RTL and testbench

//  Read-side controller for the small synchronous RAM.
//  - On a start request, walks a wrapping address counter from a base address.
//  - Issues one read strobe per word and captures the returned data.
//  - Presents each word on a valid/ready output stream, flagging the last word.
//  - Sits between the RAM read port and any consumer: datapath, display, checker.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_read_sequencer_if.sv | 24 ++
 rtl/ram_addr_counter.sv | 22 ++
 rtl/ram_read_sequencer.sv | 86 ++++++++
 tb/tb_ram_read_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the small synchronous RAM and its read-side sequencer.
// The default widths are shared with the RAM block so both sides always agree.
package ram_pkg;

   localparam int DEF_DW = 2;
   localparam int DEF_AW = 2;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_PRESENT = 3'd3;
   localparam logic [2:0] ST_FINISH  = 3'd4;

endpackage

// File: rtl/ram_read_sequencer_if.sv
// RAM read port plus valid/ready output stream of the read sequencer.
// master = sequencer side, slave = RAM/consumer side.
interface ram_read_sequencer_if #(
   parameter int DW = ram_pkg::DEF_DW,
   parameter int AW = ram_pkg::DEF_AW
);
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;

   modport master (
      output mem_rd_en, mem_addr, out_valid, out_data, out_last,
      input  mem_rdata, out_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, out_valid, out_data, out_last,
      output mem_rdata, out_ready
   );
endinterface

// File: rtl/ram_addr_counter.sv
// AW-bit wrapping address counter with synchronous load and increment-enable.
module ram_addr_counter
   import ram_pkg::*;
#(
   parameter int AW = DEF_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          inc,
   output logic [AW-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    count <= '0;
      else if (load) count <= load_val;
      else if (inc)  count <= count + AW'(1);
   end

endmodule

// File: rtl/ram_read_sequencer.sv
// Read-side controller for the small synchronous RAM: walks a wrapping address
// from base_addr, one outstanding read at a time, and streams words out.
module ram_read_sequencer
   import ram_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [AW:0]           num_words,
   output logic                  busy,
   output logic                  done,
   ram_read_sequencer_if.master  bus
);

   localparam logic [AW:0] REM_ONE = (AW+1)'(1);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [AW:0]   remaining;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_q;
   logic          last_q;
   logic          handshake;
   logic          load;

   assign handshake = (state == ST_PRESENT) && bus.out_ready;
   assign load      = (state == ST_IDLE) && start && (num_words != '0);

   ram_addr_counter #(.AW(AW)) u_addr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (base_addr),
      .inc      (handshake),
      .count    (addr)
   );

   // NOTE: assigning a default first keeps this block purely combinational (no latches).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = (num_words != '0) ? ST_ISSUE : ST_FINISH;
         ST_ISSUE:   state_nxt = ST_WAIT;
         ST_WAIT:    state_nxt = ST_PRESENT;
         ST_PRESENT: if (handshake) state_nxt = (remaining > REM_ONE) ? ST_ISSUE : ST_FINISH;
         ST_FINISH:  state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         remaining <= '0;
      else if (load)      remaining <= num_words;
      else if (handshake) remaining <= remaining - REM_ONE;
   end

   // Captured in WAIT, the cycle the RAM returns data, then held through PRESENT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         last_q <= 1'b0;
      end else if (state == ST_WAIT) begin
         data_q <= bus.mem_rdata;
         last_q <= (remaining == REM_ONE);
      end
   end

   // Decoded from the state register so the reset clears out_valid asynchronously.
   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_FINISH);
   assign bus.mem_rd_en = (state == ST_ISSUE);
   assign bus.mem_addr  = addr;
   assign bus.out_valid = (state == ST_PRESENT);
   assign bus.out_data  = data_q;
   assign bus.out_last  = last_q;

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Randomized self-checking bench: a behavioural RAM plus a burst model that
// predicts addresses, words, last flags and timing from base/length alone.
module tb_ram_read_sequencer;
   import ram_pkg::*;

   localparam int DW     = DEF_DW;
   localparam int AW     = DEF_AW;
   localparam int DEPTH  = 1 << AW;
   localparam int BUDGET = 300;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   num_words = '0;
   logic          busy;
   logic          done;
   logic [DW-1:0] mem [DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   ram_read_sequencer_if #(.DW(DW), .AW(AW)) bus ();

   ram_read_sequencer #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // mode 0: ready always high (exact timing checked); 1: random ready;
   // 2: ready low for the first 5 valid cycles, then high. inj: cycle to pulse a stray start.
   task automatic run_burst(input int base, input int n, input int mode, input int inj);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] held_data;
      logic          held_last;
      bit            held_v   = 0;
      bit            got_done = 0;
      int            cyc = 0, rd_idx = 0, hs_idx = 0, vcnt = 0, last_hs = 0;

      for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % DEPTH]);

      start         = 1'b1;
      base_addr     = AW'(base);
      num_words     = (AW+1)'(n);
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1 start = 1'b0;

      while (!got_done && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         check("busy", busy, 1);
         if (bus.mem_rd_en) begin
            check("rd_addr", bus.mem_addr, (base + rd_idx) % DEPTH);
            if (mode == 0) check("rd_cycle", cyc, 1 + 3 * rd_idx);
            rd_idx++;
         end
         if (bus.out_valid) begin
            vcnt++;
            check("rd_while_valid", bus.mem_rd_en, 0);
            if (mode == 0 && vcnt == 1) check("first_valid_cycle", cyc, 3);
            if (held_v) begin
               check("hold_data", bus.out_data, held_data);
               check("hold_last", bus.out_last, held_last);
            end
            if (bus.out_ready) begin
               check("word_in_burst", hs_idx < n, 1);
               if (hs_idx < n) check("data", bus.out_data, exp_q[hs_idx]);
               check("last", bus.out_last, hs_idx == n - 1);
               hs_idx++;
               last_hs = cyc;
               held_v  = 0;
            end else begin
               held_data = bus.out_data;
               held_last = bus.out_last;
               held_v    = 1;
            end
         end
         if (done) begin
            got_done = 1;
            check("done_cycle", cyc, (n == 0) ? 1 : last_hs + 1);
            check("words", hs_idx, n);
            check("reads", rd_idx, n);
         end
         @(posedge clk);
         #1;
         if (cyc == inj) begin
            start     = 1'b1;
            base_addr = AW'($urandom);
            num_words = (AW+1)'($urandom_range(1, DEPTH));
         end else begin
            start = 1'b0;
         end
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = (vcnt >= 5);
         endcase
      end
      if (!got_done) check("timeout", 0, 1);
      start = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
   endtask

   task automatic reset_mid_burst();
      int cyc = 0;
      start         = 1'b1;
      base_addr     = AW'(1);
      num_words     = (AW+1)'(4);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      // With ready high the second word is presented in cycle 6.
      while (cyc < 6) begin
         @(negedge clk);
         cyc++;
      end
      check("second_present", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", bus.out_valid, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_done", done, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_done", done, 0);
         check("rst_hold_rd", bus.mem_rd_en, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_done", done, 0);
         check("post_rst_busy", busy, 0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_en", bus.mem_rd_en, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_last", bus.out_last, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_no_rd", bus.mem_rd_en, 0);
      end
      @(posedge clk);
      #1;

      // Directed bursts on the preloaded pattern {01,10,11,00}
      run_burst(0, 4, 0, -1);
      run_burst(3, 3, 0, -1);
      run_burst(1, 2, 2, -1);
      run_burst(2, 0, 0, -1);
      run_burst(0, 4, 0, 5);
      run_burst(2, 1, 0, -1);
      reset_mid_burst();
      run_burst(2, 3, 0, -1);

      // Randomized bursts with fresh RAM contents
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
         run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                   (t % 5 == 0) ? 0 : 1, (t % 7 == 3) ? 4 : -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
